multi_gate_pipe: RTL and testbench
==================================

// Module: multi_gate_pipe
// PURPOSE
// - Parametrised, pipelined successor to the single 2-input gate: NUM_IN operands, each WIDTH bits wide.
// - Bitwise reduction across operands (AND/OR/XOR/NAND/NOR/XNOR/PASS), op chosen per transaction.
// - Two-stage valid/ready pipeline with back-pressure and a transaction counter.
// - Generic registered logic-gate engine for the gate examples and their test fixtures.
// PARAMETERS
// - WIDTH     4   bits per operand and per result
// - NUM_IN    2   operand count (>=2)
// - CNT_W     8   width of the transaction counter
// PORTS
// - CLK        in   1             rising-edge clock
// - RST_N      in   1             asynchronous active-low reset
// - IN_VALID   in   1             operand bundle valid
// - IN_READY   out  1             block accepts bundle this cycle
// - OP         in   3             operation code, sampled with the bundle
// - A          in   NUM_IN*WIDTH  operands, operand k at A[k*WIDTH +: WIDTH]
// - OUT_VALID  out  1             Y valid
// - OUT_READY  in   1             downstream accepts Y
// - Y          out  WIDTH         result
// - OP_ERR     out  1             result came from a reserved OP; qualified by OUT_VALID
// - COUNT      out  CNT_W         completed output handshakes
// BEHAVIOUR
// - Reset (RST_N=0, async): all valids 0, Y=0, OP_ERR=0, COUNT=0, IN_READY=0 while reset is asserted.
// - IN_READY=1 from the first CLK edge after release.
// - Handshakes:
//   - Input transfer when IN_VALID&&IN_READY.
//   - Output transfer when OUT_VALID&&OUT_READY.
//   - Y and OP_ERR hold stable while OUT_VALID&&!OUT_READY.
// - Stage S1: registers A, OP.
// - Stage S2: registers Y = f(OP, A) and OP_ERR.
// - Latency: 2 cycles, input accept edge to OUT_VALID, with no back-pressure.
// - Throughput: 1 transaction per cycle.
// - Stall rules:
//   - S2 loads when !OUT_VALID || OUT_READY.
//   - S1 loads when !s1_valid || S2 loads.
//   - IN_READY = !s1_valid || s2_load, combinational; no bubbles under sustained flow.
// - OP codes (reduction across all NUM_IN operands, bitwise):
//   - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
//   - 6 PASS (operand 0).
//   - 7 reserved: Y=0, OP_ERR=1.
// - COUNT: increments on each output transfer and wraps from 2^CNT_W-1 to 0.
// - Simultaneous events:
//   - Input and output transfer in the same cycle: both occur, pipeline occupancy unchanged.
//   - Full pipeline with OUT_READY=0: IN_READY=0, no state changes.
// - Reset mid-operation: in-flight data is discarded, nothing is emitted after release, COUNT returns to 0.
// CONFIGURATION
// - Macro MULTI_GATE_PIPE_PARITY_EN:
//   - Defined: adds output PARITY (1 bit) = ^Y, registered with Y in S2.
//   - PARITY is 0 on reset and held during stalls.
//   - Undefined: no PARITY port, no parity logic; all other behaviour identical.
// STRUCTURE
// - Shared package multi_gate_pkg:
//   - OP_AND..OP_PASS, OP_RSVD localparams (3-bit).
//   - typedef op_t.
// - Sub-module gate_reduce (combinational): WIDTH/NUM_IN params; in A, OP; out Y, ERR.
//   - Instantiated once between S1 and S2.
// - Top: pipeline registers, handshake, COUNT, optional parity.
// TESTING
// - Bench uses WIDTH=4, NUM_IN=2 unless noted.
// - Reset: RST_N=0 mid-run -> OUT_VALID=0, Y=0, COUNT=0 immediately (async); IN_READY=1 one edge after release.
// - OP=1 (OR), A={4'b0110,4'b1010}, OUT_READY=1 -> Y=4'b1110 two cycles after accept, COUNT=1.
// - Sweep OP 0..6 on A={4'b0110,4'b1010}:
//   - Y=0010, 1110, 1100, 1101, 0001, 0011, 1010 (PASS = operand 0).
//   - OP=7 -> Y=0000, OP_ERR=1.
// - NUM_IN=4, OP=2 (XOR), operands 1,2,4,8 -> Y=4'hF.
// - Back-pressure:
//   - OUT_READY=0 with 3 bundles offered -> 2 accepted, IN_READY=0, Y held.
//   - Release -> all 3 results in order, no loss or duplication.
// - COUNT wrap: CNT_W=2, 5 transfers -> COUNT sequence 1,2,3,0,1.
// - With MULTI_GATE_PIPE_PARITY_EN: Y=4'b1110 -> PARITY=1.

Source files
------------

// File: rtl/multi_gate_pkg.sv
//------------------------------------------------------------------------------
// Module  : multi_gate_pkg
// Brief   : Operation codes and the op type shared by the multi-gate pipeline.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multi_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_PASS = 3'd6;
    localparam op_t OP_RSVD = 3'd7;

endpackage : multi_gate_pkg

`default_nettype wire

// File: rtl/gate_reduce.sv
//------------------------------------------------------------------------------
// Module  : gate_reduce
// Brief   : Combinational bitwise reduction of NUM_IN operands selected by op.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gate_reduce
    import multi_gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] i_a,
    input  op_t                     i_op,
    output logic [WIDTH-1:0]        o_y,
    output logic                    o_err
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;

    always_comb begin
        w_and = i_a[WIDTH-1:0];
        w_or  = i_a[WIDTH-1:0];
        w_xor = i_a[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            w_and = w_and & i_a[k*WIDTH +: WIDTH];
            w_or  = w_or  | i_a[k*WIDTH +: WIDTH];
            w_xor = w_xor ^ i_a[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        o_y   = '0;
        o_err = 1'b0;
        case (i_op)
            OP_AND:  o_y = w_and;
            OP_OR:   o_y = w_or;
            OP_XOR:  o_y = w_xor;
            OP_NAND: o_y = ~w_and;
            OP_NOR:  o_y = ~w_or;
            OP_XNOR: o_y = ~w_xor;
            OP_PASS: o_y = i_a[WIDTH-1:0];
            default: o_err = 1'b1;
        endcase
    end

endmodule : gate_reduce

`default_nettype wire

// File: rtl/multi_gate_pipe.sv
//------------------------------------------------------------------------------
// Module  : multi_gate_pipe
// Brief   : Two-stage valid/ready gate-reduction pipeline with transfer counter.
//           Define MULTI_GATE_PIPE_PARITY_EN to add a registered parity output.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_gate_pipe
    import multi_gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  op_t                     i_op,
    input  logic [NUM_IN*WIDTH-1:0] i_a,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [WIDTH-1:0]        o_y,
    output logic                    o_op_err,
    output logic [CNT_W-1:0]        o_count
`ifdef MULTI_GATE_PIPE_PARITY_EN
    ,
    output logic                    o_parity
`endif
);

    logic                    r_run;
    logic                    r_s1_valid;
    logic [NUM_IN*WIDTH-1:0] r_s1_a;
    op_t                     r_s1_op;
    logic                    r_s2_valid;
    logic [WIDTH-1:0]        r_s2_y;
    logic                    r_s2_err;
    logic [CNT_W-1:0]        r_count;

    logic                    w_s2_load;
    logic                    w_s1_load;
    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic [WIDTH-1:0]        w_y;
    logic                    w_err;

    assign w_s2_load  = !r_s2_valid || i_out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    // r_run keeps the input closed until the first edge after reset release.
    assign o_in_ready = r_run && w_s1_load;
    assign w_in_xfer  = i_in_valid && o_in_ready;
    assign w_out_xfer = r_s2_valid && i_out_ready;

    gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_gate_reduce (
        .i_a   (r_s1_a),
        .i_op  (r_s1_op),
        .o_y   (w_y),
        .o_err (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_op    <= OP_AND;
        end else begin
            r_run <= 1'b1;
            if (w_s1_load) begin
                r_s1_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_s1_a  <= i_a;
                    r_s1_op <= i_op;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y   <= w_y;
                r_s2_err <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + 1'b1;
        end
    end

`ifdef MULTI_GATE_PIPE_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_parity <= ^w_y;
        end
    end

    assign o_parity = r_parity;
`endif

    assign o_out_valid = r_s2_valid;
    assign o_y         = r_s2_y;
    assign o_op_err    = r_s2_err;
    assign o_count     = r_count;

endmodule : multi_gate_pipe

`default_nettype wire

// File: tb/tb_multi_gate_pipe.sv
//------------------------------------------------------------------------------
// Module  : tb_multi_gate_pipe
// Brief   : Directed, table-driven bench for multi_gate_pipe (three configs).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_gate_pipe;

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [15:0] a4;
        logic [3:0]  y;
        logic        err;
        logic [3:0]  y4;
        logic        chk4;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  op;
    logic [7:0]  a2;
    logic [15:0] a4;
    logic        out_ready;

    logic        in_ready0, out_valid0, err0;
    logic [3:0]  y0;
    logic [7:0]  cnt0;
    logic        in_ready1, out_valid1, err1;
    logic [3:0]  y1;
    logic [7:0]  cnt1;
    logic        in_ready2, out_valid2, err2;
    logic [3:0]  y2;
    logic [1:0]  cnt2;
`ifdef MULTI_GATE_PIPE_PARITY_EN
    logic        par0, par1, par2;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_in;
    int   n_out;
    int   exp_cnt;
    vec_t vecs[9];
    vec_t strm[$];

    multi_gate_pipe #(.WIDTH(4), .NUM_IN(2), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready0),
        .i_op(op), .i_a(a2), .o_out_valid(out_valid0), .i_out_ready(out_ready),
        .o_y(y0), .o_op_err(err0), .o_count(cnt0)
`ifdef MULTI_GATE_PIPE_PARITY_EN
        , .o_parity(par0)
`endif
    );

    multi_gate_pipe #(.WIDTH(4), .NUM_IN(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready1),
        .i_op(op), .i_a(a4), .o_out_valid(out_valid1), .i_out_ready(out_ready),
        .o_y(y1), .o_op_err(err1), .o_count(cnt1)
`ifdef MULTI_GATE_PIPE_PARITY_EN
        , .o_parity(par1)
`endif
    );

    multi_gate_pipe #(.WIDTH(4), .NUM_IN(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
        .i_op(op), .i_a(a2), .o_out_valid(out_valid2), .i_out_ready(out_ready),
        .o_y(y2), .o_op_err(err2), .o_count(cnt2)
`ifdef MULTI_GATE_PIPE_PARITY_EN
        , .o_parity(par2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        if (n_in < strm.size()) begin
            in_valid = 1'b1;
            op       = strm[n_in].op;
            a2       = strm[n_in].a;
            a4       = strm[n_in].a4;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: observe handshakes before the edge, score outputs, advance stimulus.
    task automatic step();
        logic acc;
        logic xfer;
        @(negedge clk);
        acc  = in_valid && in_ready0;
        xfer = out_valid0 && out_ready;
        if (xfer) begin
            chk("y", y0, strm[n_out].y);
            chk("op_err", err0, strm[n_out].err);
`ifdef MULTI_GATE_PIPE_PARITY_EN
            chk("parity", par0, ^strm[n_out].y);
`endif
            if (strm[n_out].chk4) chk("y_num_in4", y1, strm[n_out].y4);
            n_out++;
        end
        @(posedge clk);
        #1;
        if (acc) n_in++;
        if (xfer) begin
            exp_cnt++;
            chk("count", cnt0, exp_cnt % 256);
            chk("count_w2", cnt2, exp_cnt % 4);
        end
        drive();
    endtask

    initial begin
        vecs[0] = '{3'd0, 8'b0110_1010, 16'h0, 4'b0010, 1'b0, 4'h0, 1'b0};
        vecs[1] = '{3'd1, 8'b0110_1010, 16'h0, 4'b1110, 1'b0, 4'h0, 1'b0};
        vecs[2] = '{3'd2, 8'b0110_1010, 16'h0, 4'b1100, 1'b0, 4'h0, 1'b0};
        vecs[3] = '{3'd3, 8'b0110_1010, 16'h0, 4'b1101, 1'b0, 4'h0, 1'b0};
        vecs[4] = '{3'd4, 8'b0110_1010, 16'h0, 4'b0001, 1'b0, 4'h0, 1'b0};
        vecs[5] = '{3'd5, 8'b0110_1010, 16'h0, 4'b0011, 1'b0, 4'h0, 1'b0};
        vecs[6] = '{3'd6, 8'b0110_1010, 16'h0, 4'b1010, 1'b0, 4'h0, 1'b0};
        vecs[7] = '{3'd7, 8'b0110_1010, 16'h0, 4'b0000, 1'b1, 4'h0, 1'b0};
        vecs[8] = '{3'd2, 8'b0000_0000, 16'h8421, 4'b0000, 1'b0, 4'hF, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a2 = '0; a4 = '0; out_ready = 1'b1;
        n_in = 0; n_out = 0; exp_cnt = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_y", y0, 4'h0);
        chk("rst_op_err", err0, 1'b0);
        chk("rst_count", cnt0, 8'h0);
        chk("rst_in_ready", in_ready0, 1'b0);
`ifdef MULTI_GATE_PIPE_PARITY_EN
        chk("rst_parity", par0, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready0, 1'b0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", in_ready0, 1'b1);

        // Sustained stream through the op table, including the NUM_IN=4 XOR case
        strm.delete();
        for (int i = 0; i < 9; i++) strm.push_back(vecs[i]);
        n_in = 0; n_out = 0;
        drive();
        for (int c = 0; c < 40 && n_out < strm.size(); c++) step();
        chk("table_drained", n_out, strm.size());

        // Back-pressure: three bundles offered while downstream stalls
        strm.delete();
        strm.push_back('{3'd1, 8'b0011_0101, 16'h0, 4'b0111, 1'b0, 4'h0, 1'b0});
        strm.push_back('{3'd2, 8'b1111_0101, 16'h0, 4'b1010, 1'b0, 4'h0, 1'b0});
        strm.push_back('{3'd6, 8'b0000_1001, 16'h0, 4'b1001, 1'b0, 4'h0, 1'b0});
        n_in = 0; n_out = 0;
        out_ready = 1'b0;
        drive();
        for (int c = 0; c < 6; c++) step();
        chk("bp_accepted", n_in, 2);
        chk("bp_in_ready", in_ready0, 1'b0);
        chk("bp_out_valid", out_valid0, 1'b1);
        chk("bp_y_held", y0, 4'b0111);
        chk("bp_count_held", cnt0, exp_cnt % 256);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && n_out < strm.size(); c++) step();
        chk("bp_drained", n_out, 3);
        for (int c = 0; c < 3; c++) step();
        chk("bp_no_dup", n_out, 3);

        // Reset with work in flight
        strm.delete();
        for (int i = 0; i < 3; i++) strm.push_back(vecs[i]);
        n_in = 0; n_out = 0;
        out_ready = 1'b0;
        drive();
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid0, 1'b0);
        chk("async_rst_y", y0, 4'h0);
        chk("async_rst_count", cnt0, 8'h0);
        chk("async_rst_count_w2", cnt2, 2'h0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (out_valid0) seen++;
            end
            chk("no_emit_after_rst", seen, 0);
        end
        chk("count_after_rst", cnt0, 8'h0);

        // Single OR transaction from a clean pipeline
        strm.delete();
        strm.push_back(vecs[1]);
        n_in = 0; n_out = 0;
        drive();
        for (int c = 0; c < 10 && n_out < 1; c++) step();
        chk("single_or_done", n_out, 1);
        chk("single_or_count", cnt0, 8'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_multi_gate_pipe

`default_nettype wire
